// File: rtl/tlp_trigger_pkg.sv
// Shared definitions for the RX TLP trigger: FSM encoding, geometry defaults
// and the gray-to-binary conversion used on the synchronised read pointer.
package tlp_trigger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_TREQ  = 3'd2,
    ST_TWAIT = 3'd3,
    ST_LAST  = 3'd4,
    ST_FLUSH = 3'd5,
    ST_HPREQ = 3'd6,
    ST_HWAIT = 3'd7
  } state_e;

  localparam int unsigned HP_LOG2_DEF = 18;
  localparam int unsigned RSV_QW_DEF  = 16;

  // Works on a 32-bit container; callers zero-extend and truncate to their width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop synchroniser, reused for the gray read pointer and each ack.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tlp_trigger_mp.sv
// RX TLP trigger: tracks committed buffer occupancy, requests max-payload TLPs
// and huge-page changes towards the 250 MHz TLP engine over four-phase handshakes.
module tlp_trigger_mp
  import tlp_trigger_pkg::*;
#(
  parameter int unsigned AW      = 10,
  parameter int unsigned MP_QW   = 16,
  parameter int unsigned HP_LOG2 = HP_LOG2_DEF,
  parameter int unsigned RSV_QW  = RSV_QW_DEF,
  parameter int unsigned TO_W    = 28
) (
  input  logic                     clk156,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [TO_W-1:0]          timeout_cycles,
  input  logic [AW-1:0]            commited_wr_address,
  input  logic [AW-1:0]            commited_rd_address_gray,
  input  logic                     trigger_tlp_ack,
  output logic                     trigger_tlp,
  input  logic                     change_huge_page_ack,
  output logic                     change_huge_page,
  output logic                     send_last_tlp_change_huge_page,
  output logic [$clog2(MP_QW):0]   qwords_to_send,
  output logic [HP_LOG2:0]         huge_page_offset,
  output logic                     busy
);

  localparam int unsigned MPL = $clog2(MP_QW);
  localparam int unsigned QW  = MPL + 1;
  localparam int unsigned OW  = HP_LOG2 + 1;
  localparam logic [OW-1:0] PAGE_QW = {1'b1, {HP_LOG2{1'b0}}};

  logic [AW-1:0]   rd_gray_s;
  logic [AW-1:0]   rd_bin;
  logic            trig_ack_s;
  logic            chg_ack_s;
  logic [AW-1:0]   avail_q;

  state_e          state_q;
  logic [OW-1:0]   offset_q;
  logic [OW-1:0]   lookahead_q;
  logic [MPL-1:0]  remaining_q;
  logic [MPL-1:0]  rem_new_q;
  logic [AW-1:0]   ntlp_q;
  logic [AW-1:0]   sent_q;
  logic            dirty_q;
  logic [QW-1:0]   qwords_q;
  logic            trig_q;
  logic            chg_q;
  logic            last_q;

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            to_hit;
  logic [1:0]      settle_q;
  logic            idle_go;

  sync_2ff #(.W(AW)) u_sync_rd (
    .clk_i  (clk156),
    .rst_ni (reset_n),
    .d_i    (commited_rd_address_gray),
    .q_o    (rd_gray_s)
  );

  sync_2ff #(.W(1)) u_sync_tack (
    .clk_i  (clk156),
    .rst_ni (reset_n),
    .d_i    (trigger_tlp_ack),
    .q_o    (trig_ack_s)
  );

  sync_2ff #(.W(1)) u_sync_cack (
    .clk_i  (clk156),
    .rst_ni (reset_n),
    .d_i    (change_huge_page_ack),
    .q_o    (chg_ack_s)
  );

  assign rd_bin = AW'(gray2bin(32'(rd_gray_s)));

  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      avail_q <= '0;
    end else begin
      avail_q <= commited_wr_address - rd_bin;
    end
  end

  // Idle-flush counter: runs only while idle and enabled, parks on the threshold.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_IDLE && enable) begin
      to_cnt_d = (to_cnt_q == timeout_cycles) ? to_cnt_q : to_cnt_q + TO_W'(1);
    end
  end

  assign to_hit = (timeout_cycles != '0) && (to_cnt_q == timeout_cycles);

  // After reset the synchronisers and avail_q need three edges to hold real
  // samples; decisions before that would act on reset zeros.
  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      settle_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // A stale ack from before reset must be seen low before any new request.
  assign idle_go = enable && (settle_q == 2'd3) && !trig_ack_s && !chg_ack_s;

  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      offset_q    <= OW'(RSV_QW);
      lookahead_q <= '0;
      remaining_q <= '0;
      rem_new_q   <= '0;
      ntlp_q      <= '0;
      sent_q      <= '0;
      dirty_q     <= 1'b0;
      qwords_q    <= QW'(MP_QW);
      trig_q      <= 1'b0;
      chg_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (idle_go) begin
            if (avail_q >= AW'(MP_QW)) begin
              ntlp_q      <= avail_q >> MPL;
              rem_new_q   <= avail_q[MPL-1:0];
              lookahead_q <= offset_q + OW'(avail_q);
              state_q     <= ST_CHECK;
            end else if (to_hit && dirty_q) begin
              state_q <= ST_FLUSH;
            end else if (to_hit && avail_q != '0) begin
              qwords_q <= QW'(avail_q);
              state_q  <= ST_LAST;
            end
          end
        end

        ST_CHECK: begin
          dirty_q <= 1'b1;
          if (lookahead_q >= PAGE_QW) begin
            if (remaining_q == '0) begin
              chg_q   <= 1'b1;
              state_q <= ST_HPREQ;
            end else begin
              qwords_q <= QW'(remaining_q);
              state_q  <= ST_LAST;
            end
          end else begin
            remaining_q <= rem_new_q;
            sent_q      <= '0;
            qwords_q    <= QW'(MP_QW);
            trig_q      <= 1'b1;
            state_q     <= ST_TREQ;
          end
        end

        ST_TREQ: begin
          if (trig_ack_s) begin
            trig_q   <= 1'b0;
            offset_q <= offset_q + OW'(MP_QW);
            sent_q   <= sent_q + AW'(1);
            state_q  <= ST_TWAIT;
          end
        end

        ST_TWAIT: begin
          if (!trig_ack_s) begin
            if (sent_q < ntlp_q) begin
              trig_q  <= 1'b1;
              state_q <= ST_TREQ;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_LAST: begin
          last_q  <= 1'b1;
          chg_q   <= 1'b1;
          state_q <= ST_HPREQ;
        end

        ST_FLUSH: begin
          if (remaining_q == '0) begin
            chg_q   <= 1'b1;
            state_q <= ST_HPREQ;
          end else begin
            qwords_q <= QW'(remaining_q);
            state_q  <= ST_LAST;
          end
        end

        ST_HPREQ: begin
          if (chg_ack_s) begin
            chg_q       <= 1'b0;
            last_q      <= 1'b0;
            offset_q    <= OW'(RSV_QW);
            remaining_q <= '0;
            dirty_q     <= 1'b0;
            state_q     <= ST_HWAIT;
          end
        end

        ST_HWAIT: begin
          if (!chg_ack_s) state_q <= ST_IDLE;
        end

        default: begin
          trig_q  <= 1'b0;
          chg_q   <= 1'b0;
          last_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign trigger_tlp                    = trig_q;
  assign change_huge_page               = chg_q;
  assign send_last_tlp_change_huge_page = last_q;
  assign qwords_to_send                 = qwords_q;
  assign huge_page_offset               = offset_q;
  assign busy                           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tlp_trigger_mp.sv
// Randomised bench for tlp_trigger_mp: acts as the TLP engine and compares every
// request against a transaction-level model of the buffer/page bookkeeping.
module tb_tlp_trigger_mp;

  localparam int AW    = 10;
  localparam int MP    = 16;
  localparam int HPL   = 10;
  localparam int RSV   = 16;
  localparam int TOW   = 16;
  localparam int PAGE  = 1 << HPL;
  localparam int PMASK = (1 << AW) - 1;

  localparam int K_TLP  = 0;
  localparam int K_HP   = 1;
  localparam int K_LAST = 2;

  logic           clk156 = 1'b0;
  logic           reset_n = 1'b1;
  logic           enable = 1'b0;
  logic [TOW-1:0] timeout_cycles = '0;
  logic [AW-1:0]  wr_addr = '0;
  logic [AW-1:0]  rd_gray = '0;
  logic           t_ack = 1'b0;
  logic           c_ack = 1'b0;
  logic           trig;
  logic           chg;
  logic           last;
  logic [4:0]     qw;
  logic [HPL:0]   off;
  logic           busy;

  tlp_trigger_mp #(
    .AW(AW), .MP_QW(MP), .HP_LOG2(HPL), .RSV_QW(RSV), .TO_W(TOW)
  ) dut (
    .clk156                         (clk156),
    .reset_n                        (reset_n),
    .enable                         (enable),
    .timeout_cycles                 (timeout_cycles),
    .commited_wr_address            (wr_addr),
    .commited_rd_address_gray       (rd_gray),
    .trigger_tlp_ack                (t_ack),
    .trigger_tlp                    (trig),
    .change_huge_page_ack           (c_ack),
    .change_huge_page               (chg),
    .send_last_tlp_change_huge_page (last),
    .qwords_to_send                 (qw),
    .huge_page_offset               (off),
    .busy                           (busy)
  );

  always #5 clk156 = ~clk156;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int kind;
    int qw;
    int off;
  } req_t;

  req_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_ptr, rd_ptr;
  int   m_off, m_rem, m_dirty;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_ptrs();
    int r;
    wr_ptr  = wr_ptr & PMASK;
    rd_ptr  = rd_ptr & PMASK;
    r       = rd_ptr;
    wr_addr = AW'(wr_ptr);
    rd_gray = AW'(r ^ (r >> 1));
  endtask

  task automatic push_exp(input int kind, input int q, input int o);
    req_t e;
    e.kind = kind;
    e.qw   = q;
    e.off  = o;
    expq.push_back(e);
  endtask

  task automatic model_reset();
    m_off   = RSV;
    m_rem   = 0;
    m_dirty = 0;
  endtask

  // Everything the buffer holds is drained in max-payload TLPs until less than
  // one payload remains; a page that cannot take it is closed first.
  task automatic model_drain();
    int rd, avail;
    rd    = rd_ptr;
    avail = (wr_ptr - rd) & PMASK;
    while (avail >= MP) begin
      m_dirty = 1;
      if (m_off + avail >= PAGE) begin
        push_exp((m_rem == 0) ? K_HP : K_LAST, m_rem, m_off);
        rd      = rd + m_rem;
        m_off   = RSV;
        m_rem   = 0;
        m_dirty = 0;
      end else begin
        for (int k = 0; k < avail / MP; k++) begin
          push_exp(K_TLP, MP, m_off);
          m_off = m_off + MP;
          rd    = rd + MP;
        end
        m_rem = avail % MP;
      end
      avail = (wr_ptr - rd) & PMASK;
    end
  endtask

  task automatic model_timeout();
    int avail;
    avail = (wr_ptr - rd_ptr) & PMASK;
    if (m_dirty != 0) begin
      push_exp((m_rem == 0) ? K_HP : K_LAST, m_rem, m_off);
      model_reset();
    end else if (avail > 0) begin
      push_exp(K_LAST, avail, m_off);
      model_reset();
    end
  endtask

  task automatic serve(input int hold);
    req_t e;
    int   n, viol, kind;
    n = 0;
    while (!trig && !chg && n < 300) begin
      @(negedge clk156);
      n++;
    end
    e = expq.pop_front();
    chk("req_seen", 32'(trig | chg), 1);
    if (!trig && !chg) return;
    kind = trig ? K_TLP : (last ? K_LAST : K_HP);
    chk("req_kind", kind, e.kind);
    chk("req_offset", 32'(off), e.off);
    if (e.kind != K_HP) chk("req_qwords", 32'(qw), e.qw);
    repeat ($urandom_range(0, 3)) @(negedge clk156);
    if (trig) t_ack = 1'b1;
    else c_ack = 1'b1;
    if (e.kind != K_HP) rd_ptr = rd_ptr + e.qw;
    apply_ptrs();
    n = 0;
    while ((trig || chg || last) && n < 50) begin
      @(negedge clk156);
      n++;
    end
    chk("req_dropped_on_ack", 32'(trig | chg | last), 0);
    viol = 0;
    repeat (hold) begin
      @(negedge clk156);
      if (trig || chg) viol++;
    end
    chk("req_low_while_ack", viol, 0);
    t_ack = 1'b0;
    c_ack = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    int seen;
    seen = 0;
    repeat (30) begin
      @(negedge clk156);
      if (trig || chg) seen++;
    end
    chk({tag, "_no_extra_req"}, seen, 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_offset"}, 32'(off), m_off);
  endtask

  task automatic serve_all(input int hold);
    while (expq.size() > 0) serve(hold);
  endtask

  task automatic run_round(input string tag);
    apply_ptrs();
    model_drain();
    while (expq.size() > 0) serve($urandom_range(0, 4));
    settle_check(tag);
  endtask

  initial begin
    int n, seen;

    // Reset with a read pointer just below the wrap point.
    wr_ptr = 3;
    rd_ptr = 1020;
    apply_ptrs();
    enable = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk156);
    chk("rst_trigger", 32'(trig), 0);
    chk("rst_change", 32'(chg), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_qwords", 32'(qw), MP);
    chk("rst_offset", 32'(off), RSV);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    model_reset();

    // Wrapped avail of 7 never starts a TLP and a zero timeout never fires.
    seen = 0;
    repeat (200) begin
      @(negedge clk156);
      if (trig || chg || busy) seen++;
    end
    chk("wrap_no_req", seen, 0);

    timeout_cycles = TOW'(100);
    n = 0;
    while (!chg && n < 200) begin
      @(negedge clk156);
      n++;
    end
    chk("timeout_window", 32'((n >= 95) && (n <= 110)), 1);
    model_timeout();
    serve_all(2);
    timeout_cycles = '0;
    settle_check("wrap_timeout");

    // Forty QWORDs from a fresh page: two payloads, eight left behind.
    wr_ptr = wr_ptr + 40;
    run_round("two_tlp");

    // Ack held high for a long time after each request.
    wr_ptr = wr_ptr + 24;
    apply_ptrs();
    model_drain();
    serve_all(50);
    settle_check("long_ack");

    // Disabled: data arrives but nothing is requested until re-enabled.
    enable = 1'b0;
    wr_ptr = wr_ptr + 40;
    apply_ptrs();
    seen = 0;
    repeat (100) begin
      @(negedge clk156);
      if (trig || chg || busy) seen++;
    end
    chk("disabled_no_req", seen, 0);
    enable = 1'b1;
    run_round("reenable");

    // Random arrivals spanning several page changes.
    for (int it = 0; it < 70; it++) begin
      wr_ptr = wr_ptr + $urandom_range(1, 70);
      run_round("rand");
    end

    // Idle flush of a dirty page.
    timeout_cycles = TOW'(50);
    model_timeout();
    serve_all(1);
    timeout_cycles = '0;
    settle_check("flush");

    // Reset asserted while a TLP request is outstanding, with the ack left high.
    wr_ptr = wr_ptr + 40;
    apply_ptrs();
    n = 0;
    while (!trig && n < 300) begin
      @(negedge clk156);
      n++;
    end
    chk("rst_mid_treq_seen", 32'(trig), 1);
    t_ack = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_async_drop", 32'(trig), 0);
    chk("rst_mid_async_busy", 32'(busy), 0);
    repeat (3) @(negedge clk156);
    reset_n = 1'b1;
    chk("rst_mid_offset", 32'(off), RSV);
    model_reset();
    seen = 0;
    repeat (30) begin
      @(negedge clk156);
      if (trig || chg) seen++;
    end
    chk("stale_ack_absorbed", seen, 0);
    t_ack = 1'b0;
    run_round("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
